// File: rtl/usb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// usb_uart_tx_fifo
//
// Transmit-side byte buffer sitting in front of usb_uart's write port, all in
// the clk_48mhz domain. Producers push bytes over a valid/ready handshake; the
// buffer drains them into usb_uart over uart_we/uart_di/uart_wait, one byte
// per cycle while usb_uart keeps accepting. This decouples bursty producers
// from USB host polling stalls.
//
// Parameters:
//   DEPTH_LOG2  FIFO storage depth is 2**DEPTH_LOG2 bytes. The output holding
//               register (uart_di) adds one more byte of buffering.
//
// Ports:
//   clk_48mhz  in   1             system clock, rising edge
//   reset      in   1             synchronous active-high reset
//   in_data    in   8             byte from producer
//   in_valid   in   1             in_data valid
//   in_ready   out  1             buffer can accept; byte taken on in_valid & in_ready
//   flush      in   1             synchronous clear of stored bytes
//   uart_di    out  8             byte presented to usb_uart
//   uart_we    out  1             write request to usb_uart
//   uart_wait  in   1             usb_uart busy; byte taken on uart_we & !uart_wait
//   level      out  DEPTH_LOG2+1  bytes stored in the FIFO (excludes uart_di)
//
// Configuration macro:
//   TX_CRLF_EN  when defined, every 0x0A leaving the FIFO is preceded by an
//               inserted 0x0D. When undefined, bytes pass through verbatim.
// -----------------------------------------------------------------------------
module usb_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [7:0]            uart_di,
  output logic                  uart_we,
  input  logic                  uart_wait,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  logic       empty;
  logic       full;
  logic       push;
  logic       accept;
  logic       fifo_avail;
  logic       load;
  logic       pop;
  logic [7:0] head;
  logic [7:0] load_data;

`ifdef TX_CRLF_EN
  logic cr_sent;
  logic insert_cr;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // without a separate counter.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // in_ready is derived purely from registered pointers, so a pop in the same
  // cycle never lets a full FIFO accept; this keeps in_ready free of any
  // combinational path from uart_wait.
  assign in_ready = !full && !reset;

  // A flush wins over a simultaneous push: the pushed byte is dropped.
  assign push = in_valid && in_ready && !flush;

  assign accept = uart_we && !uart_wait;

  // During a flush the FIFO contents are being discarded, so nothing may be
  // loaded from it; the byte already on uart_di is left to finish normally.
  assign fifo_avail = !empty && !flush;

  assign uart_we = (state == SEND);

`ifdef TX_CRLF_EN
  // A 0x0A at the head that has not yet been preceded by a CR gets a 0x0D
  // presented first, without popping the 0x0A.
  assign insert_cr = (head == 8'h0A) && !cr_sent;
`endif

  // State register.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. SEND persists across back-to-back bytes and only falls
  // back to IDLE when an accept finds nothing more to send.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fifo_avail) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept && !fifo_avail) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: decide whether the holding register is refilled this
  // cycle, with which byte, and whether the FIFO head is consumed.
  always_comb begin
    load      = 1'b0;
    pop       = 1'b0;
    load_data = head;
    case (state)
      IDLE:    load = fifo_avail;
      SEND:    load = accept && fifo_avail;
      default: load = 1'b0;
    endcase
`ifdef TX_CRLF_EN
    if (insert_cr) begin
      load_data = 8'h0D;
    end
    pop = load && !insert_cr;
`else
    pop = load;
`endif
  end

  // FIFO storage. No reset needed: contents are only observed through the
  // pointers, which are reset.
  always_ff @(posedge clk_48mhz) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  // FIFO pointers. Flush empties the FIFO by snapping the read pointer onto
  // the write pointer; push and pop are both blocked while flushing.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Output holding register. It only changes when a new byte is loaded, so
  // uart_di stays stable while usb_uart stalls.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      uart_di <= 8'h00;
    end else if (load) begin
      uart_di <= load_data;
    end
  end

`ifdef TX_CRLF_EN
  // cr_sent remembers that the CR for the current head 0x0A is already out,
  // so the next load sends the 0x0A itself and pops it.
  always_ff @(posedge clk_48mhz) begin
    if (reset || flush) begin
      cr_sent <= 1'b0;
    end else if (load) begin
      cr_sent <= insert_cr;
    end
  end
`endif

endmodule

// File: tb/tb_usb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_usb_uart_tx_fifo
//
// Self-checking bench for usb_uart_tx_fifo. Every byte the producer hands over
// is pushed onto an expected-byte queue (with a 0x0D inserted ahead of 0x0A
// when TX_CRLF_EN is defined); a monitor pops and compares one entry for each
// byte usb_uart would accept. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_usb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk_48mhz = 1'b0;
  logic                reset     = 1'b1;
  logic [7:0]          in_data   = 8'h00;
  logic                in_valid  = 1'b0;
  logic                in_ready;
  logic                flush     = 1'b0;
  logic [7:0]          uart_di;
  logic                uart_we;
  logic                uart_wait = 1'b0;
  logic [DEPTH_LOG2:0] level;

  logic [7:0] exp_q[$];
  int         errors     = 0;
  int         checks     = 0;
  int         accept_cnt = 0;

  usb_uart_tx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .uart_di  (uart_di),
    .uart_we  (uart_we),
    .uart_wait(uart_wait),
    .level    (level)
  );

  // 10-unit clock period.
  always #5 clk_48mhz = ~clk_48mhz;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Record what usb_uart should eventually receive for one producer byte.
  task automatic expectByte(input logic [7:0] b);
`ifdef TX_CRLF_EN
    if (b == 8'h0A) begin
      exp_q.push_back(8'h0D);
    end
`endif
    exp_q.push_back(b);
  endtask

  // Offer one byte and hold it until the handshake completes (bounded).
  // Called and returns at 1 unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk_48mhz);
      done = in_ready;
      @(posedge clk_48mhz);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("push_accepted", {31'd0, done}, 32'd1);
    if (done) begin
      expectByte(b);
    end
  endtask

  // Wait until every expected byte has gone out and the write port is idle.
  task automatic waitIdle(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk_48mhz);
      done = (exp_q.size() == 0) && (uart_we == 1'b0);
    end
    checkOutput(tag, {31'd0, done}, 32'd1);
    @(posedge clk_48mhz);
    #1;
  endtask

  // Scoreboard monitor: each cycle usb_uart would take a byte, it must match
  // the oldest outstanding expected byte, and one must be outstanding.
  always @(negedge clk_48mhz) begin
    if (!reset && uart_we === 1'b1 && uart_wait === 1'b0) begin
      accept_cnt++;
      checkOutput("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        checkOutput("uart_di", {24'd0, uart_di}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Guards against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int crlf_extra;

`ifdef TX_CRLF_EN
    crlf_extra = 1;
`else
    crlf_extra = 0;
`endif

    // Reset state, including in_ready held low while reset is asserted.
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_uart_we", {31'd0, uart_we}, 32'd0);
    checkOutput("rst_uart_di", {24'd0, uart_di}, 32'h00);
    checkOutput("rst_level", {27'd0, level}, 32'd0);
    @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    @(negedge clk_48mhz);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk_48mhz);
    #1;

    // Test 1: single-byte latency, one-cycle write pulse.
    $display("[TB] test 1: single byte latency");
    base     = accept_cnt;
    in_data  = 8'h41;
    in_valid = 1'b1;
    expectByte(8'h41);
    @(posedge clk_48mhz);
    #1;
    in_valid = 1'b0;
    @(negedge clk_48mhz);
    checkOutput("t1_we_edge_e", {31'd0, uart_we}, 32'd0);
    checkOutput("t1_level_edge_e", {27'd0, level}, 32'd1);
    @(negedge clk_48mhz);
    checkOutput("t1_we_edge_e1", {31'd0, uart_we}, 32'd1);
    checkOutput("t1_di_edge_e1", {24'd0, uart_di}, 32'h41);
    checkOutput("t1_level_edge_e1", {27'd0, level}, 32'd0);
    @(negedge clk_48mhz);
    checkOutput("t1_we_edge_e2", {31'd0, uart_we}, 32'd0);
    checkOutput("t1_accepts", accept_cnt - base, 32'd1);
    @(posedge clk_48mhz);
    #1;

    // Test 2: fill to capacity under stall, then a gap-free burst.
    $display("[TB] test 2: capacity and back-to-back drain");
    uart_wait = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(8'(i));
    end
    @(negedge clk_48mhz);
    checkOutput("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
    checkOutput("t2_level_full", {27'd0, level}, DEPTH);
    @(posedge clk_48mhz);
    #1;
    in_data  = 8'hEE;
    in_valid = 1'b1;
    repeat (3) @(posedge clk_48mhz);
    #1;
    in_valid = 1'b0;
    @(negedge clk_48mhz);
    checkOutput("t2_level_overfill", {27'd0, level}, DEPTH);
    @(posedge clk_48mhz);
    #1;
    n         = exp_q.size();
    base      = accept_cnt;
    uart_wait = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_48mhz);
      checkOutput($sformatf("t2_burst_we_%0d", i), {31'd0, uart_we}, 32'd1);
    end
    @(negedge clk_48mhz);
    checkOutput("t2_we_after_burst", {31'd0, uart_we}, 32'd0);
    checkOutput("t2_accepts", accept_cnt - base, DEPTH + 1 + crlf_extra);
    checkOutput("t2_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk_48mhz);
    #1;

    // Test 3: byte held stable across a stall, accepted exactly once.
    $display("[TB] test 3: stall hold");
    uart_wait = 1'b1;
    base      = accept_cnt;
    applyStimulus(8'h55);
    @(posedge clk_48mhz);
    #1;
    for (int i = 0; i < 3; i++) begin
      uart_wait = (i == 2) ? 1'b0 : 1'b1;
      @(negedge clk_48mhz);
      checkOutput($sformatf("t3_di_%0d", i), {24'd0, uart_di}, 32'h55);
      checkOutput($sformatf("t3_we_%0d", i), {31'd0, uart_we}, 32'd1);
      @(posedge clk_48mhz);
      #1;
    end
    @(negedge clk_48mhz);
    checkOutput("t3_we_after", {31'd0, uart_we}, 32'd0);
    checkOutput("t3_accepts", accept_cnt - base, 32'd1);
    @(posedge clk_48mhz);
    #1;

    // Test 4: flush a full FIFO; only the held byte survives.
    $display("[TB] test 4: flush");
    uart_wait = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(8'(i));
    end
    flush = 1'b1;
    @(posedge clk_48mhz);
    #1;
    flush = 1'b0;
    while (exp_q.size() > 1) begin
      void'(exp_q.pop_back());
    end
    @(negedge clk_48mhz);
    checkOutput("t4_level_flushed", {27'd0, level}, 32'd0);
    checkOutput("t4_we_held", {31'd0, uart_we}, 32'd1);
    checkOutput("t4_di_held", {24'd0, uart_di}, 32'h00);
    @(posedge clk_48mhz);
    #1;
    base      = accept_cnt;
    uart_wait = 1'b0;
    repeat (10) @(negedge clk_48mhz);
    checkOutput("t4_accepts", accept_cnt - base, 32'd1);
    checkOutput("t4_we_idle", {31'd0, uart_we}, 32'd0);
    checkOutput("t4_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk_48mhz);
    #1;

    // Test 5: line feed handling.
    $display("[TB] test 5: line feed");
    base = accept_cnt;
    applyStimulus(8'h41);
    applyStimulus(8'h0A);
    waitIdle("t5_drained");
    checkOutput("t5_accepts", accept_cnt - base, 2 + crlf_extra);

    // Test 6: reset in the middle of a drain discards everything.
    $display("[TB] test 6: reset mid-drain");
    uart_wait = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h80 + 8'(i));
    end
    base      = accept_cnt;
    uart_wait = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    reset = 1'b1;
    @(negedge clk_48mhz);
    checkOutput("t6_in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk_48mhz);
    #1;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk_48mhz);
    checkOutput("t6_we_after_reset", {31'd0, uart_we}, 32'd0);
    checkOutput("t6_level_after_reset", {27'd0, level}, 32'd0);
    checkOutput("t6_di_after_reset", {24'd0, uart_di}, 32'h00);
    repeat (20) @(negedge clk_48mhz);
    checkOutput("t6_accepts", accept_cnt - base, 32'd3);
    checkOutput("t6_we_quiet", {31'd0, uart_we}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
